// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: one request outstanding at a time, completed by a one-cycle ack.
interface if_fetch_unit_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: generates the fetch PC, runs the memory req/ack handshake,
// drops stale fetches after a branch and holds a completed word while the pipeline is frozen.
module if_fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] PC_INC   = DATA_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_addr,
  if_fetch_unit_if.master   mem,
  output logic              valid,
  output logic [DATA_W-1:0] PC_out,
  output logic [DATA_W-1:0] instruction
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DROP  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_tgt, w_tgt_nxt;
  logic [DATA_W-1:0] r_buf, w_buf_nxt;
  logic [DATA_W-1:0] r_bufpc, w_bufpc_nxt;
  logic [DATA_W-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + PC_INC;

  // No request is driven while reset is held, so memory never sees a half-reset handshake.
  assign mem.mem_req  = rst && (r_state != S_HOLD);
  assign mem.mem_addr = r_pc;

  always_comb begin
    valid       = 1'b0;
    PC_out      = '0;
    instruction = '0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          if (mem.mem_ack && !branch_taken) begin
            valid       = 1'b1;
            PC_out      = w_pc_inc;
            instruction = mem.mem_rdata;
          end
        end
        S_HOLD: begin
          if (!branch_taken) begin
            valid       = 1'b1;
            PC_out      = r_bufpc;
            instruction = r_buf;
          end
        end
        default: begin
          valid = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_buf_nxt   = r_buf;
    w_bufpc_nxt = r_bufpc;
    case (r_state)
      S_FETCH: begin
        if (mem.mem_ack) begin
          if (branch_taken) begin
            w_pc_nxt = branch_addr;
          end else begin
            w_pc_nxt = w_pc_inc;
            if (freeze) begin
              w_buf_nxt   = mem.mem_rdata;
              w_bufpc_nxt = w_pc_inc;
              w_state_nxt = S_HOLD;
            end
          end
        end else if (branch_taken) begin
          // Address must stay stable until the outstanding request acks, so park the target.
          w_tgt_nxt   = branch_addr;
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (mem.mem_ack) begin
          w_pc_nxt    = branch_taken ? branch_addr : r_tgt;
          w_state_nxt = S_FETCH;
        end else if (branch_taken) begin
          w_tgt_nxt = branch_addr;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          w_pc_nxt    = branch_addr;
          w_state_nxt = S_FETCH;
        end else if (!freeze) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_buf   <= '0;
      r_bufpc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_buf   <= w_buf_nxt;
      r_bufpc <= w_bufpc_nxt;
    end
  end

endmodule
